calc_arbiter: RTL
=================

CALC_ARBITER -- requirements
Module: calc_arbiter

Interface
REQ-001 Parameter: WIDTH, default 5, operand/result width shared with the addsub datapath.
REQ-002 Parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-003 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: req_valid_i  input  2  per-requester operation request; bit n is requester n.
REQ-006 Port: req_ready_o  output  2  per-requester accept; one-hot or zero.
REQ-007 Port: req_a_i  input  2*WIDTH  operand A; requester n at [n*WIDTH +: WIDTH].
REQ-008 Port: req_b_i  input  2*WIDTH  operand B, same packing.
REQ-009 Port: req_mode_i  input  2  per-requester mode: 0 add, 1 subtract.
REQ-010 Port: rsp_valid_o  output  2  result valid for requester n; one-hot or zero.
REQ-011 Port: rsp_ready_i  input  2  per-requester result accept.
REQ-012 Port: rsp_result_o  output  WIDTH  shared result bus, meaningful only while any rsp_valid_o bit is high.
REQ-013 Port: dp_a_o, dp_b_o  output  WIDTH each  operands driven to the external addsub.
REQ-014 Port: dp_mode_o  output  1  mode driven to the external addsub.
REQ-015 Port: dp_result_i  input  WIDTH  combinational result returned by the addsub.
REQ-016 Port: busy_o  output  1  high in any state other than IDLE.
REQ-017 Port: op_count_o  output  CNT_W  count of completed responses.

Function
REQ-018 The FSM SHALL have states IDLE, CALC, RESP; transitions IDLE->CALC on accept, CALC->RESP unconditionally after one cycle, RESP->IDLE on rsp_ready_i[owner].
REQ-019 In IDLE, req_ready_o SHALL be asserted combinationally for the granted requester only; outside IDLE, req_ready_o SHALL be 0.
REQ-020 Accept SHALL occur on an edge where req_valid_i[n] and req_ready_o[n] are both high; operands, mode and owner index are then latched.
REQ-021 Requesters SHALL hold valid and operands stable until accepted; if valid drops before accept, no transaction occurs.
REQ-022 dp_a_o, dp_b_o and dp_mode_o SHALL be driven only from the latched registers, never directly from request inputs.
REQ-023 At the end of CALC, dp_result_i SHALL be registered into the result register.
REQ-024 Latency SHALL be fixed: accept at edge N gives rsp_valid_o[owner] high from the cycle after edge N+1; the minimum issue interval is 3 cycles.
REQ-025 In RESP, rsp_valid_o[owner] and rsp_result_o SHALL hold until rsp_ready_i[owner]; rsp_ready_i of the non-owner SHALL be ignored.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH, with no overflow flag (31+1=0, 0-1=31 at WIDTH=5).
REQ-027 Arbitration SHALL be round-robin: with both requesting, grant the requester not served last; with one requesting, grant it regardless.
REQ-028 The last-served pointer SHALL update on response completion, not on accept.
REQ-029 op_count_o SHALL increment on each RESP->IDLE transition and wrap to 0 at 2^CNT_W.
REQ-030 The block SHALL NOT accept a new request on the same edge that a response completes; a new accept is possible from the next IDLE cycle.

Reset
REQ-031 When rst_ni is low, the block SHALL asynchronously force: state=IDLE, operand/result/mode registers=0, owner=0, last-served pointer=1 (requester 0 wins first contention), op_count_o=0.
REQ-032 During reset, all of req_ready_o, rsp_valid_o and busy_o SHALL be 0.
REQ-033 Reset mid-transaction SHALL discard that transaction with no response and no count increment.

Configuration
REQ-034 The macro CALC_ARBITER_FIXED_PRIO_EN SHALL select the arbitration policy.
REQ-035 With the macro defined, requester 0 SHALL always win contention and the last-served pointer SHALL be absent.
REQ-036 Without the macro, round-robin per REQ-027/REQ-028 applies.

Verification
REQ-037 Reset release, requester 0 issues a=3, b=4, add -> req_ready_o=01 at accept, rsp_valid_o=01 two cycles later, result=7, op_count_o=1.
REQ-038 Requester 1 issues a=0, b=1, sub, then a=31, b=1, add -> results 31 then 0 (wrap).
REQ-039 Both requesters held valid continuously, rsp_ready always 1 -> grants alternate 0,1,0,1; with CALC_ARBITER_FIXED_PRIO_EN -> always 0.
REQ-040 Owner holds rsp_ready_i=0 for 5 cycles while the other asserts rsp_ready_i -> rsp_valid_o and result stable, no new accept, busy_o=1.
REQ-041 rst_ni pulsed low in CALC -> immediate IDLE, outputs 0, no response, op_count_o unchanged at 0.

Source files
------------

// File: rtl/calc_arbiter.sv
// calc_arbiter: two-requester front end for a shared external add/subtract unit.
//
// One operation is in flight at a time. In IDLE a single requester is granted
// (req_ready_o is combinational on req_valid_i). The accepted operands are
// latched and presented to the external datapath for one CALC cycle. The
// datapath's combinational answer is registered, then held in RESP until the
// owner takes it.
//
// Arbitration policy:
//   CALC_ARBITER_FIXED_PRIO_EN undefined (default) : round-robin, pointer
//                                                    updated on completion
//   CALC_ARBITER_FIXED_PRIO_EN defined             : requester 0 always wins
module calc_arbiter #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [1:0]         req_valid_i,
    output logic [1:0]         req_ready_o,
    input  logic [2*WIDTH-1:0] req_a_i,
    input  logic [2*WIDTH-1:0] req_b_i,
    input  logic [1:0]         req_mode_i,
    output logic [1:0]         rsp_valid_o,
    input  logic [1:0]         rsp_ready_i,
    output logic [WIDTH-1:0]   rsp_result_o,
    output logic [WIDTH-1:0]   dp_a_o,
    output logic [WIDTH-1:0]   dp_b_o,
    output logic               dp_mode_o,
    input  logic [WIDTH-1:0]   dp_result_i,
    output logic               busy_o,
    output logic [CNT_W-1:0]   op_count_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic             owner_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             mode_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] count_reg;

    logic             grant_idx;
    logic             grant_any;
    logic             in_idle;
    logic             accept;
    logic             complete;

    // Grants are only offered in IDLE and never while reset is held, since
    // the asynchronous reset parks the FSM in IDLE.
    assign in_idle   = (state_reg == ST_IDLE) && rst_ni;
    assign grant_any = |req_valid_i;

`ifdef CALC_ARBITER_FIXED_PRIO_EN
    // Fixed priority: requester 1 is chosen only when requester 0 is silent.
    always_comb begin
        grant_idx = ~req_valid_i[0];
    end
`else
    logic last_reg;

    // Round-robin: on contention pick whoever was not served last; a lone
    // requester is picked regardless of the pointer.
    always_comb begin
        if (req_valid_i == 2'b11) begin
            grant_idx = ~last_reg;
        end else begin
            grant_idx = ~req_valid_i[0];
        end
    end

    // Last-served pointer moves when a response completes, not at accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_reg <= 1'b1;
        end else if (complete) begin
            last_reg <= owner_reg;
        end
    end
`endif

    // Per-requester handshake decode: ready for the granted one in IDLE,
    // response valid for the owner in RESP.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready_o[gi] = in_idle && grant_any && (grant_idx == 1'(gi));
            assign rsp_valid_o[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign accept   = |(req_valid_i & req_ready_o);
    assign complete = (state_reg == ST_RESP) && rsp_ready_i[owner_reg];

    // Next-state logic: one cycle of CALC is the fixed datapath latency.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)   state_next = ST_CALC;
            ST_CALC:               state_next = ST_RESP;
            ST_RESP: if (complete) state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture operands, mode and owner of the accepted request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_reg     <= '0;
            b_reg     <= '0;
            mode_reg  <= 1'b0;
            owner_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= grant_idx ? req_a_i[WIDTH +: WIDTH] : req_a_i[0 +: WIDTH];
            b_reg     <= grant_idx ? req_b_i[WIDTH +: WIDTH] : req_b_i[0 +: WIDTH];
            mode_reg  <= grant_idx ? req_mode_i[1] : req_mode_i[0];
            owner_reg <= grant_idx;
        end
    end

    // Register the external datapath's answer at the end of CALC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_reg <= '0;
        end else if (state_reg == ST_CALC) begin
            result_reg <= dp_result_i;
        end
    end

    // Completed-operation counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (complete) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // The datapath only ever sees latched values, so it is stable through
    // CALC even if requesters change their inputs after accept.
    assign dp_a_o       = a_reg;
    assign dp_b_o       = b_reg;
    assign dp_mode_o    = mode_reg;
    assign rsp_result_o = result_reg;
    assign busy_o       = (state_reg != ST_IDLE);
    assign op_count_o   = count_reg;

endmodule
